bin2seg_seq: RTL
================

Name: bin2seg_seq

Overview:
- Sequential, parametrised binary-to-seven-segment display driver.
- Converts an N-bit unsigned value to DIGITS decimal digits using iterative shift-add-3 (double dabble), one input bit per clock.
- Drives DIGITS active-low 7-segment patterns, with optional leading-zero blanking and overflow indication.
- Sits between counter/ALU result registers and the board HEX displays; generalises the existing 2-digit combinational decoder to any width and digit count.

Parameters:
- N, 6, input value width in bits (1..32).
- DIGITS, 2, number of decimal digits displayed (1..8).
- BLANK_LZ, 1, 1 = blank leading zero digits (ones digit never blanked); 0 = show all digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of number; sampled only in IDLE.
- number  input  N  unsigned binary value, latched on accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when segments/bcd/overflow update.
- overflow  output  1  number >= 10**DIGITS for the last conversion.
- bcd  output  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
- segments  output  7*DIGITS  active-low patterns, bit order g f e d c b a per digit. Digit i (0 = ones) occupies [7*(DIGITS-i)-1 : 7*(DIGITS-1-i)]; the ones digit is in the MSBs, the most significant digit in [6:0].

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, overflow=0, bcd=0, segments all 1 (blank). Reset mid-conversion aborts; no done pulse.
- States: IDLE -> CONV -> LOAD -> IDLE.
- IDLE: start=1 latches number into the shift register, clears the BCD accumulator, computes overflow_pending = (number >= 10**DIGITS), loads bit counter = N, and moves to CONV.
- CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,shift} left 1. Decrement the counter; on the last of N shifts go to LOAD. busy=1 throughout.
- LOAD (1 cycle): update bcd, segments and overflow registers; done=1, busy=0; next state IDLE.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+N+1. Back-to-back: start high in the done cycle is not accepted; it is accepted at the next edge, when the FSM is back in IDLE.
- start while CONV/LOAD: ignored, no queueing. number changes after acceptance have no effect.
- Outputs hold their last values between conversions.
- Digit encoding (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble = 1111111.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blank (1111111) if it and all higher digits are 0. The bcd output is not blanked.
- Overflow: overflow=1; every digit shows dash 0111111; bcd = all 4'hF. Blanking is not applied.
- Width rules:
  - Internal BCD accumulator is 4*DIGITS bits; bits shifted beyond it are discarded. This is harmless because overflow is decided from the latched compare.
  - 10**DIGITS is evaluated at elaboration in at least 34 bits.

Test Plan:
- Reset, then N=6, DIGITS=2, number=0, start -> done 7 cycles after start; segments=14'b1000000_1111111, bcd=8'h00, overflow=0.
- number=63 -> segments=14'b0110000_0000010, bcd=8'h63; busy high exactly 6 cycles. number=9 -> segments=14'b0010000_1111111.
- BLANK_LZ=0, number=5 -> segments=14'b0010010_1000000; confirm the tens digit is not blanked.
- N=8, DIGITS=2, number=150 -> overflow=1, segments=14'b0111111_0111111, bcd=8'hFF. Then number=99 -> overflow=0, bcd=8'h99.
- start=1 held continuously with number changing mid-conversion -> result reflects only the latched value; next conversion begins one cycle after done; exactly one done per conversion.
- Assert rst_n=0 during CONV cycle 3 -> busy=0, segments all 1 immediately, no done pulse; a new start after release converts correctly.

Source files
------------

// File: rtl/bin2seg_seq.sv
// bin2seg_seq: sequential binary-to-seven-segment driver.
// Converts an N-bit unsigned value to DIGITS decimal digits with double
// dabble (one input bit per clock), then registers packed BCD, active-low
// gfedcba segment patterns and an overflow flag in a single load cycle.
module bin2seg_seq #(
    parameter int N        = 6,
    parameter int DIGITS   = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N-1:0]          number,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   segments
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(N + 1);

    // 10**DIGITS held in 64 bits so eight digits never wrap.
    function automatic logic [63:0] pow10(input int d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < d; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        return r;
    endfunction

    // Active-low gfedcba encoding; non-decimal nibbles are blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    shreg;
    logic [BW-1:0]   acc;
    logic            ovf_pend;
    logic [SW-1:0]   seg_next;
    logic            higher_zero;
    logic [3:0]      dig;

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = CONV;
            CONV: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath: latch operand, then shift-add-3 once per CONV cycle.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            shreg    <= number;
            acc      <= '0;
            ovf_pend <= ({{(64-N){1'b0}}, number} >= LIMIT);
        end else if (state_q == CONV) begin
            shreg <= shreg << 1;
            acc   <= (add3(acc) << 1) | {{(BW-1){1'b0}}, shreg[N-1]};
        end
    end

    // Segment patterns from the finished accumulator, top digit first so
    // leading-zero blanking can track whether every higher digit was zero.
    always_comb begin
        seg_next    = '1;
        higher_zero = 1'b1;
        dig         = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = acc[4*i +: 4];
            if (ovf_pend)
                seg_next[7*(DIGITS-1-i) +: 7] = 7'b0111111;
            else if (BLANK_LZ != 0 && i > 0 && higher_zero && dig == 4'd0)
                seg_next[7*(DIGITS-1-i) +: 7] = 7'b1111111;
            else
                seg_next[7*(DIGITS-1-i) +: 7] = seg7(dig);
            higher_zero = higher_zero & (dig == 4'd0);
        end
    end

    // Down-counter of remaining shifts plus the result registers, which
    // change only in LOAD and otherwise hold the last conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            segments <= '1;
        end else begin
            done <= (state_q == LOAD);
            if (state_q == IDLE && start) cnt <= CW'(N);
            else if (state_q == CONV)     cnt <= cnt - CW'(1);
            if (state_q == LOAD) begin
                overflow <= ovf_pend;
                bcd      <= ovf_pend ? {BW{1'b1}} : acc;
                segments <= seg_next;
            end
        end
    end

endmodule
